// File: rtl/traffic_walk_ctrl.sv
// Main/side intersection controller with latched pedestrian walk phase and one-shot green extension.
// Latency: lamps and WalkPending are registered; state advances only on OneHzEn ticks.
module traffic_walk_ctrl #(
    parameter int T_BASE = 6,
    parameter int T_EXT  = 3,
    parameter int T_YEL  = 2,
    parameter int T_WALK = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic OneHzEn,
    input  logic WalkEn,
    input  logic Sensor,
    output logic MainGrn,
    output logic MainYel,
    output logic MainRed,
    output logic SideGrn,
    output logic SideYel,
    output logic SideRed,
    output logic WalkLamp,
    output logic WalkPending
);

    typedef enum logic [2:0] {
        MAIN_GRN,
        MAIN_YEL,
        WALK,
        SIDE_GRN,
        SIDE_YEL
    } state_t;

    // The counter only has to reach the longest state's last tick.
    localparam int D_GRN = T_BASE + T_EXT;
    localparam int D_M1  = (D_GRN > T_YEL) ? D_GRN : T_YEL;
    localparam int D_MAX = (D_M1 > T_WALK) ? D_M1 : T_WALK;
    localparam int CW    = (D_MAX > 1) ? $clog2(D_MAX) : 1;

    localparam logic [CW-1:0] C_BASE_LAST = CW'(T_BASE - 1);
    localparam logic [CW-1:0] C_EXT_LAST  = CW'(T_BASE + T_EXT - 1);
    localparam logic [CW-1:0] C_YEL_LAST  = CW'(T_YEL - 1);
    localparam logic [CW-1:0] C_WALK_LAST = CW'(T_WALK - 1);

    state_t          r_state;
    logic [CW-1:0]   r_tcnt;
    logic            r_ext;
    logic            r_pend;
    logic [6:0]      r_lamps;

    logic [CW-1:0]   w_dur_last;
    logic            w_green;
    logic            w_ext_hit;
    logic            w_exit;
    state_t          w_next;

    // Lamp order: {MainGrn, MainYel, MainRed, SideGrn, SideYel, SideRed, WalkLamp}
    function automatic logic [6:0] lamps_of(input state_t s);
        case (s)
            MAIN_GRN: lamps_of = 7'b1000010;
            MAIN_YEL: lamps_of = 7'b0100010;
            WALK:     lamps_of = 7'b0010011;
            SIDE_GRN: lamps_of = 7'b0011000;
            SIDE_YEL: lamps_of = 7'b0010100;
            default:  lamps_of = 7'b1000010;
        endcase
    endfunction

    always_comb begin
        w_dur_last = C_YEL_LAST;
        w_next     = r_state;
        case (r_state)
            MAIN_GRN, SIDE_GRN: w_dur_last = r_ext ? C_EXT_LAST : C_BASE_LAST;
            WALK:               w_dur_last = C_WALK_LAST;
            default:            w_dur_last = C_YEL_LAST;
        endcase
        w_green   = (r_state == MAIN_GRN) || (r_state == SIDE_GRN);
        // Sensor at the base-green boundary buys one extension instead of an exit.
        w_ext_hit = w_green && !r_ext && Sensor && (r_tcnt == C_BASE_LAST);
        w_exit    = OneHzEn && !w_ext_hit && (r_tcnt == w_dur_last);
        case (r_state)
            MAIN_GRN: w_next = MAIN_YEL;
            MAIN_YEL: w_next = r_pend ? WALK : SIDE_GRN;
            WALK:     w_next = SIDE_GRN;
            SIDE_GRN: w_next = SIDE_YEL;
            SIDE_YEL: w_next = MAIN_GRN;
            default:  w_next = MAIN_GRN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= MAIN_GRN;
            r_tcnt  <= '0;
            r_ext   <= 1'b0;
            r_pend  <= 1'b0;
            r_lamps <= lamps_of(MAIN_GRN);
        end else begin
            if (OneHzEn) begin
                if (w_exit) begin
                    r_state <= w_next;
                    r_tcnt  <= '0;
                    r_ext   <= 1'b0;
                    r_lamps <= lamps_of(w_next);
                end else begin
                    r_tcnt <= r_tcnt + 1'b1;
                    if (w_ext_hit)
                        r_ext <= 1'b1;
                end
            end
            // Entering WALK services the request; that clear beats a same-edge press.
            if (w_exit && (w_next == WALK))
                r_pend <= 1'b0;
            else if (WalkEn && (r_state != WALK))
                r_pend <= 1'b1;
        end
    end

    assign MainGrn     = r_lamps[6];
    assign MainYel     = r_lamps[5];
    assign MainRed     = r_lamps[4];
    assign SideGrn     = r_lamps[3];
    assign SideYel     = r_lamps[2];
    assign SideRed     = r_lamps[1];
    assign WalkLamp    = r_lamps[0];
    assign WalkPending = r_pend;

endmodule

// File: tb/tb_traffic_walk_ctrl.sv
// Scoreboard bench for traffic_walk_ctrl: per-cycle expected lamp/pending vectors are queued
// from phase tables and compared one cycle at a time after each clock edge.
module tb_traffic_walk_ctrl;

    logic clk = 1'b0;
    logic rst, OneHzEn, WalkEn, Sensor;
    logic MainGrn, MainYel, MainRed, SideGrn, SideYel, SideRed, WalkLamp, WalkPending;

    traffic_walk_ctrl dut (
        .clk(clk), .rst(rst), .OneHzEn(OneHzEn), .WalkEn(WalkEn), .Sensor(Sensor),
        .MainGrn(MainGrn), .MainYel(MainYel), .MainRed(MainRed),
        .SideGrn(SideGrn), .SideYel(SideYel), .SideRed(SideRed),
        .WalkLamp(WalkLamp), .WalkPending(WalkPending)
    );

    always #5 clk = ~clk;

    // {MainGrn, MainYel, MainRed, SideGrn, SideYel, SideRed, WalkLamp}
    localparam logic [6:0] L_MG = 7'b1000010;
    localparam logic [6:0] L_MY = 7'b0100010;
    localparam logic [6:0] L_WK = 7'b0010011;
    localparam logic [6:0] L_SG = 7'b0011000;
    localparam logic [6:0] L_SY = 7'b0010100;

    logic [7:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    int edge_n = 0;
    int tick_div = 1;

    function automatic logic [7:0] obs();
        return {MainGrn, MainYel, MainRed, SideGrn, SideYel, SideRed, WalkLamp, WalkPending};
    endfunction

    task automatic check_dat(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%b exp=%b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic [6:0] lamp, input logic pend, input int n);
        repeat (n) exp_q.push_back({lamp, pend});
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            edge_n++;
            OneHzEn = ((edge_n % tick_div) == 0);
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL %s scoreboard underflow got=%b exp=none", tag, obs());
            end else begin
                check_dat(tag, obs(), exp_q.pop_front());
            end
        end
    endtask

    // Called one time unit after a rising edge so rst lands well away from any edge.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        check_dat({tag, "_async"}, obs(), {L_MG, 1'b0});
        @(posedge clk);
        #1;
        check_dat({tag, "_hold"}, obs(), {L_MG, 1'b0});
        rst = 1'b0;
        edge_n = 0;
    endtask

    initial begin
        OneHzEn = 1'b1;
        WalkEn  = 1'b0;
        Sensor  = 1'b0;
        rst     = 1'b0;

        // Basic cycle, no sensor, no walk
        do_reset("rst_basic");
        push(L_MG, 0, 5); push(L_MY, 0, 2); push(L_SG, 0, 6); push(L_SY, 0, 2);
        push(L_MG, 0, 6); push(L_MY, 0, 2); push(L_SG, 0, 6); push(L_SY, 0, 2);
        push(L_MG, 0, 1);
        run(32, "basic");

        // Sensor held high: each green is 9 ticks, never 12
        do_reset("rst_ext");
        Sensor = 1'b1;
        push(L_MG, 0, 8); push(L_MY, 0, 2); push(L_SG, 0, 9); push(L_SY, 0, 2);
        push(L_MG, 0, 9); push(L_MY, 0, 1);
        run(31, "ext");
        Sensor = 1'b0;

        // Two-cycle walk press in MAIN_GRN
        do_reset("rst_walk");
        push(L_MG, 0, 2); run(2, "walk_pre");
        WalkEn = 1'b1;
        push(L_MG, 1, 2); run(2, "walk_press");
        WalkEn = 1'b0;
        push(L_MG, 1, 1); push(L_MY, 1, 2); push(L_WK, 0, 3); push(L_SG, 0, 6);
        push(L_SY, 0, 2); push(L_MG, 0, 2);
        run(16, "walk");

        // Press held on the WALK entry edge and through WALK, then a press in SIDE_YEL
        do_reset("rst_bound");
        WalkEn = 1'b1;
        push(L_MG, 1, 1); run(1, "bnd_press");
        WalkEn = 1'b0;
        push(L_MG, 1, 4); push(L_MY, 1, 2); run(6, "bnd_pre");
        WalkEn = 1'b1;
        push(L_WK, 0, 3); run(3, "bnd_entry");
        WalkEn = 1'b0;
        push(L_SG, 0, 6); push(L_SY, 0, 1); run(7, "bnd_nowalk");
        WalkEn = 1'b1;
        push(L_SY, 1, 1); run(1, "bnd_sy_press");
        WalkEn = 1'b0;
        push(L_MG, 1, 6); push(L_MY, 1, 2); push(L_WK, 0, 3); push(L_SG, 0, 1);
        run(12, "bnd_sy_walk");

        // Tick every 4th cycle: MAIN_GRN spans 24 cycles
        do_reset("rst_gate");
        tick_div = 4;
        push(L_MG, 0, 23); push(L_MY, 0, 8); push(L_SG, 0, 4);
        run(35, "gate");
        tick_div = 1;

        // Reset asserted in the middle of WALK
        do_reset("rst_mw");
        WalkEn = 1'b1;
        push(L_MG, 1, 1); run(1, "mw_press");
        WalkEn = 1'b0;
        push(L_MG, 1, 4); push(L_MY, 1, 2); push(L_WK, 0, 1); run(7, "mw_to_walk");
        do_reset("mid_walk");
        push(L_MG, 0, 5); push(L_MY, 0, 1); run(6, "mw_after");

        // Reset during an extension with a request pending
        do_reset("rst_me");
        Sensor = 1'b1;
        WalkEn = 1'b1;
        push(L_MG, 1, 1); run(1, "me_press");
        WalkEn = 1'b0;
        push(L_MG, 1, 6); run(6, "me_ext");
        do_reset("mid_ext");
        Sensor = 1'b0;
        push(L_MG, 0, 5); push(L_MY, 0, 1); run(6, "me_after");

        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/traffic_walk_ctrl.md
TRAFFIC_WALK_CTRL -- requirements
Module: traffic_walk_ctrl

Interface
REQ-001 SHALL have parameter T_BASE, default 6, green base duration in ticks.
REQ-002 SHALL have parameter T_EXT, default 3, one-time green extension in ticks when Sensor is asserted.
REQ-003 SHALL have parameter T_YEL, default 2, yellow duration in ticks.
REQ-004 SHALL have parameter T_WALK, default 3, all-red walk duration in ticks.
REQ-005 SHALL have port clk, input, 1, single clock; all state changes on posedge clk.
REQ-006 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-007 SHALL have port OneHzEn, input, 1, one-cycle tick enable; the only event that advances timing.
REQ-008 SHALL have port WalkEn, input, 1, walk request from the button debouncer; a level pulse of 1 or more cycles.
REQ-009 SHALL have port Sensor, input, 1, side-road traffic present.
REQ-010 SHALL have ports MainGrn, MainYel, MainRed, output, 1 each, main-road lamps.
REQ-011 SHALL have ports SideGrn, SideYel, SideRed, output, 1 each, side-road lamps.
REQ-012 SHALL have port WalkLamp, output, 1, pedestrian walk lamp.
REQ-013 SHALL have port WalkPending, output, 1, latched walk request not yet serviced.

Function
REQ-014 SHALL implement a five-state FSM with the following transitions:
- MAIN_GRN -> MAIN_YEL
- MAIN_YEL -> WALK if WalkPending, else -> SIDE_GRN
- WALK -> SIDE_GRN
- SIDE_GRN -> SIDE_YEL
- SIDE_YEL -> MAIN_GRN
REQ-015 SHALL keep a tick counter tcnt that clears to 0 on every state entry and increments on each cycle with OneHzEn=1.
REQ-016 SHALL leave a state on the clock edge where OneHzEn=1 and tcnt == dur-1, where dur is the current state's duration; a state therefore lasts exactly dur ticks.
REQ-017 SHALL set state durations as follows:
- MAIN_GRN and SIDE_GRN: T_BASE, or T_BASE+T_EXT when extended
- yellow states: T_YEL
- WALK: T_WALK
REQ-018 SHALL extend a green state when Sensor=1 on the tick where tcnt == T_BASE-1:
- sets flag ext instead of exiting
- at most one extension per green visit
- ext clears on state exit
REQ-019 SHALL set WalkPending on any clock edge with WalkEn=1, in any state except WALK.
REQ-020 SHALL clear WalkPending on the edge that enters WALK; clear wins over a simultaneous set.
REQ-021 SHALL ignore WalkEn while in WALK.
REQ-022 SHALL decode outputs only from the state register (Moore), as follows:
- MAIN_GRN = MainGrn, SideRed
- MAIN_YEL = MainYel, SideRed
- WALK = MainRed, SideRed, WalkLamp
- SIDE_GRN = MainRed, SideGrn
- SIDE_YEL = MainRed, SideYel
REQ-023 SHALL drive exactly one lamp per road at all times, and SHALL drive WalkLamp only in WALK.
REQ-024 SHALL hold state, tcnt and ext unchanged on cycles with OneHzEn=0; WalkPending may still set on those cycles.
REQ-025 SHALL size tcnt to hold T_BASE+T_EXT-1 with no wrap; tcnt never exceeds dur-1.

Reset
REQ-026 SHALL, while rst=1, immediately force the following, regardless of clk:
- state = MAIN_GRN
- tcnt = 0
- ext = 0
- WalkPending = 0
REQ-027 SHALL present outputs MainGrn=1 and SideRed=1 during reset, with all other outputs at 0.
REQ-028 SHALL, on a mid-operation reset (including during WALK or an extension), abandon the cycle in progress and restart at the MAIN_GRN reset values.

Verification (OneHzEn tied to 1 unless stated)
REQ-029 SHALL cover the basic cycle: Sensor=0, WalkEn=0 -> the following sequence, repeating:
- MAIN_GRN for 6 cycles
- MAIN_YEL for 2
- SIDE_GRN for 6
- SIDE_YEL for 2
- WalkLamp never 1
REQ-030 SHALL cover extension: Sensor=1 constant -> each green lasts 9 cycles, never 12.
REQ-031 SHALL cover a walk request: WalkEn pulsed 2 cycles during MAIN_GRN -> expect:
- WalkPending=1 the next cycle
- after MAIN_YEL, WALK for 3 cycles with MainRed=SideRed=WalkLamp=1
- WalkPending=0 from WALK entry
- then SIDE_GRN
REQ-032 SHALL cover boundary requests:
- WalkEn=1 on the edge entering WALK -> WalkPending=0 afterwards, and no second WALK in that cycle
- WalkEn during SIDE_YEL -> WALK occurs after the next MAIN_YEL
REQ-033 SHALL cover tick gating: OneHzEn pulsed once every 4 cycles -> MAIN_GRN lasts 24 cycles, and state holds between ticks.
REQ-034 SHALL cover mid-operation reset: rst asserted mid-WALK, off a clock edge -> outputs go to MainGrn=1, SideRed=1, WalkLamp=0 and WalkPending=0 without waiting for clk, and after release MAIN_GRN lasts a full 6 cycles.
